// File: rtl/button_debounce_fsm.sv
// Pushbutton conditioner: two-flop synchroniser, 4-state debounce FSM with a stability
// counter, registered level plus single-cycle rise/fall strobes for the sequence detector.
module button_debounce_fsm #(
  parameter int unsigned STABLE_CYCLES = 240000,
  parameter bit          INVERT        = 1'b0,
  parameter int unsigned CNT_W         = $clog2(STABLE_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic db_level,
  output logic db_rise,
  output logic db_fall
);

  typedef enum logic [1:0] {
    StLowStable  = 2'd0,
    StWaitHigh   = 2'd1,
    StHighStable = 2'd2,
    StWaitLow    = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(STABLE_CYCLES - 1);

  logic             x;
  logic             s1_q;
  logic             sync_q;
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;

  assign x = btn_in ^ INVERT;

  // btn_in is asynchronous; only sync_q may feed the FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q   <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      s1_q   <= x;
      sync_q <= s1_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StLowStable;
      cnt_q    <= '0;
      db_level <= 1'b0;
      db_rise  <= 1'b0;
      db_fall  <= 1'b0;
    end else begin
      db_rise <= 1'b0;
      db_fall <= 1'b0;
      case (state_q)
        StLowStable: begin
          if (sync_q) begin
            state_q <= StWaitHigh;
            cnt_q   <= '0;
          end
        end
        StWaitHigh: begin
          // A return to 0 abandons qualification; the next departure restarts at cnt=0.
          if (!sync_q) begin
            state_q <= StLowStable;
          end else if (cnt_q == CntLast) begin
            state_q  <= StHighStable;
            db_level <= 1'b1;
            db_rise  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StHighStable: begin
          if (!sync_q) begin
            state_q <= StWaitLow;
            cnt_q   <= '0;
          end
        end
        StWaitLow: begin
          if (sync_q) begin
            state_q <= StHighStable;
          end else if (cnt_q == CntLast) begin
            state_q  <= StLowStable;
            db_level <= 1'b0;
            db_fall  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q  <= StLowStable;
          cnt_q    <= '0;
          db_level <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_debounce_fsm.sv
// Directed bench for button_debounce_fsm with STABLE_CYCLES=4; a second instance covers INVERT=1.
module tb_button_debounce_fsm;

  logic clk;
  logic reset;
  logic btn;
  logic btn_n;
  logic level, rise, fall;
  logic level_n, rise_n, fall_n;

  int tests;
  int fails;

  button_debounce_fsm #(.STABLE_CYCLES(4), .INVERT(1'b0)) dut (
    .clk(clk), .reset(reset), .btn_in(btn),
    .db_level(level), .db_rise(rise), .db_fall(fall)
  );

  button_debounce_fsm #(.STABLE_CYCLES(4), .INVERT(1'b1)) dut_inv (
    .clk(clk), .reset(reset), .btn_in(btn_n),
    .db_level(level_n), .db_rise(rise_n), .db_fall(fall_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    btn   = 1'b0;
    btn_n = 1'b1;
    apply_reset();
    tests++;
    if ({level, rise, fall} !== 3'b000) begin
      fails++;
      $display("FAIL reset_outputs: got %b expected 000", {level, rise, fall});
    end
    btn = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      tick();
      tests++;
      if ({level, rise, fall} !== {1'(e >= 7), 1'(e == 7), 1'b0}) begin
        fails++;
        $display("FAIL rise_edge%0d: got %b expected %b", e, {level, rise, fall},
                 {1'(e >= 7), 1'(e == 7), 1'b0});
      end
    end
  endtask

  task automatic test_fall();
    btn = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      tick();
      tests++;
      if ({level, rise, fall} !== {1'(e < 7), 1'b0, 1'(e == 7)}) begin
        fails++;
        $display("FAIL fall_edge%0d: got %b expected %b", e, {level, rise, fall},
                 {1'(e < 7), 1'b0, 1'(e == 7)});
      end
    end
  endtask

  // Samples 1,0,1,0,1 then held 1: the last 1 lands on edge 5, so db_rise is due at edge 11.
  task automatic test_bounce();
    logic [4:0] pat;
    pat = 5'b10101;
    for (int e = 1; e <= 13; e++) begin
      btn = (e <= 5) ? pat[5-e] : 1'b1;
      tick();
      tests++;
      if ({level, rise, fall} !== {1'(e >= 11), 1'(e == 11), 1'b0}) begin
        fails++;
        $display("FAIL bounce_edge%0d: got %b expected %b", e, {level, rise, fall},
                 {1'(e >= 11), 1'(e == 11), 1'b0});
      end
    end
  endtask

  // A 3-sample pulse never reaches terminal count; a fresh press then needs the full 7 edges.
  task automatic test_glitch();
    btn = 1'b0;
    apply_reset();
    for (int e = 1; e <= 10; e++) begin
      btn = (e <= 3) ? 1'b1 : 1'b0;
      tick();
      tests++;
      if ({level, rise, fall} !== 3'b000) begin
        fails++;
        $display("FAIL glitch_edge%0d: got %b expected 000", e, {level, rise, fall});
      end
    end
    btn = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      tests++;
      if ({level, rise} !== {1'(e >= 7), 1'(e == 7)}) begin
        fails++;
        $display("FAIL glitch_requal_edge%0d: got %b expected %b", e, {level, rise},
                 {1'(e >= 7), 1'(e == 7)});
      end
    end
  endtask

  task automatic test_async_reset();
    btn = 1'b0;
    apply_reset();
    btn = 1'b1;
    repeat (5) tick();
    #2 reset = 1'b1;
    #1;
    tests++;
    if ({level, rise, fall} !== 3'b000) begin
      fails++;
      $display("FAIL async_reset_wait: got %b expected 000", {level, rise, fall});
    end
    @(posedge clk);
    #1 reset = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      tests++;
      if ({level, rise, fall} !== {1'(e >= 7), 1'(e == 7), 1'b0}) begin
        fails++;
        $display("FAIL async_requal_edge%0d: got %b expected %b", e, {level, rise, fall},
                 {1'(e >= 7), 1'(e == 7), 1'b0});
      end
    end
    // Reset while the output is high must clear it before the next clock edge.
    #2 reset = 1'b1;
    #1;
    tests++;
    if ({level, rise, fall} !== 3'b000) begin
      fails++;
      $display("FAIL async_reset_high: got %b expected 000", {level, rise, fall});
    end
    @(posedge clk);
    #1 reset = 1'b0;
    btn = 1'b0;
  endtask

  task automatic test_invert();
    btn_n = 1'b1;
    apply_reset();
    btn_n = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      tests++;
      if ({level_n, rise_n, fall_n} !== {1'(e >= 7), 1'(e == 7), 1'b0}) begin
        fails++;
        $display("FAIL invert_edge%0d: got %b expected %b", e, {level_n, rise_n, fall_n},
                 {1'(e >= 7), 1'(e == 7), 1'b0});
      end
    end
    // Downstream detector samples w every clock: it must see a steady 1.
    for (int e = 1; e <= 8; e++) begin
      tick();
      tests++;
      if ({level_n, fall_n} !== 2'b10) begin
        fails++;
        $display("FAIL invert_w_clean%0d: got %b expected 10", e, {level_n, fall_n});
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    btn   = 1'b0;
    btn_n = 1'b1;
    test_reset();
    test_fall();
    test_bounce();
    test_glitch();
    test_async_reset();
    test_invert();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
